// File: rtl/preprocessor_pkg.sv
// Shared defaults, FSM state type and saturation helper for the EEG preprocessing front end.
package preprocessor_pkg;

  localparam int          DW         = 32;
  localparam int unsigned NTAPS      = 8;
  localparam int unsigned ALPHA      = 32440;
  localparam int unsigned LOG2_NTAPS = $clog2(NTAPS);

  typedef enum logic [1:0] {StIdle, StDcb, StMac, StOut} state_e;

  // Clamp a wide signed value into a w-bit two's complement range (w <= 62).
  function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/dc_blocker.sv
// First-order IIR DC blocker, combinational: y = sat(x - x_prev + floor(ALPHA * y_prev / 2^15)).
module dc_blocker import preprocessor_pkg::*; #(
  parameter int          DW    = preprocessor_pkg::DW,
  parameter int unsigned ALPHA = preprocessor_pkg::ALPHA
) (
  input  logic signed [DW-1:0] x,
  input  logic signed [DW-1:0] x_prev,
  input  logic signed [DW-1:0] y_prev,
  output logic signed [DW-1:0] y
);

  localparam int PW = DW + 17;

  logic signed [DW:0]   d;
  logic signed [PW-1:0] alpha_ext;
  logic signed [PW-1:0] y_ext;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] p;
  logic signed [63:0]   sum;

  always_comb begin
    d         = {x[DW-1], x} - {x_prev[DW-1], x_prev};
    alpha_ext = PW'(ALPHA);
    y_ext     = {{17{y_prev[DW-1]}}, y_prev};
    prod      = alpha_ext * y_ext;
    p         = prod >>> 15;
    // Both terms are sign-extended to 64 bits so the sum can never wrap before clamping.
    sum       = {{(64 - DW - 1){d[DW]}}, d} + {{(64 - PW){p[PW-1]}}, p};
    y         = DW'(sat(sum, DW));
  end

endmodule

// File: rtl/preprocessor_top.sv
// EEG front end: strobe synchronizer, DC blocker and NTAPS-tap moving-average FIR,
// sequenced by a small FSM that processes one sample per strobe.
module preprocessor_top import preprocessor_pkg::*; #(
  parameter int          DW    = preprocessor_pkg::DW,
  parameter int unsigned NTAPS = preprocessor_pkg::NTAPS,
  parameter int unsigned ALPHA = preprocessor_pkg::ALPHA
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sampling_clk,
  input  logic                 enable,
  input  logic signed [DW-1:0] in_signal,
  output logic signed [DW-1:0] out_signal
);

  localparam int unsigned LG = $clog2(NTAPS);
  localparam int          AW = DW + LG;

  logic                 sync1_q, sync2_q, sync3_q;
  logic                 tick;
  state_e               state_q, state_d;
  logic signed [DW-1:0] x_q, x_prev_q, y_prev_q, y;
  logic signed [DW-1:0] taps_q [NTAPS];
  logic signed [AW-1:0] acc_q;
  logic [LG-1:0]        k_q;

  assign tick = sync2_q & ~sync3_q;

  dc_blocker #(
    .DW    (DW),
    .ALPHA (ALPHA)
  ) u_dc_blocker (
    .x      (x_q),
    .x_prev (x_prev_q),
    .y_prev (y_prev_q),
    .y      (y)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (tick && enable) state_d = StDcb;
      StDcb:   state_d = StMac;
      StMac:   if (k_q == LG'(NTAPS - 1)) state_d = StOut;
      StOut:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      sync3_q    <= 1'b0;
      state_q    <= StIdle;
      x_q        <= '0;
      x_prev_q   <= '0;
      y_prev_q   <= '0;
      acc_q      <= '0;
      k_q        <= '0;
      out_signal <= '0;
      for (int unsigned i = 0; i < NTAPS; i++) taps_q[i] <= '0;
    end else begin
      sync1_q <= sampling_clk;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      state_q <= state_d;
      case (state_q)
        StIdle: if (tick && enable) x_q <= in_signal;
        StDcb: begin
          x_prev_q  <= x_q;
          y_prev_q  <= y;
          taps_q[0] <= y;
          for (int unsigned i = 1; i < NTAPS; i++) taps_q[i] <= taps_q[i-1];
          acc_q     <= '0;
          k_q       <= '0;
        end
        StMac: begin
          acc_q <= acc_q + AW'(taps_q[k_q]);
          k_q   <= k_q + LG'(1);
        end
        // The shifted mean of NTAPS DW-bit values always fits back into DW bits.
        StOut:   out_signal <= DW'(acc_q >>> LG);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_preprocessor_top.sv
// Bench for preprocessor_top: hand-derived vector table, reset/saturation sequences and a
// randomized run against a bit-exact reference model through an expected-value queue.
module tb_preprocessor_top;

  localparam int DW    = 32;
  localparam int NTAPS = 8;
  localparam int ALPHA = 32440;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 sampling_clk;
  logic                 enable;
  logic signed [DW-1:0] in_signal;
  logic signed [DW-1:0] out_signal;

  always #5 clk = ~clk;

  preprocessor_top #(
    .DW    (DW),
    .NTAPS (NTAPS),
    .ALPHA (ALPHA)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sampling_clk (sampling_clk),
    .enable       (enable),
    .in_signal    (in_signal),
    .out_signal   (out_signal)
  );

  typedef struct {
    logic signed [DW-1:0] din;
    logic                 en;
    logic signed [DW-1:0] exp_out;
  } vec_t;

  vec_t                 vecs [8];
  logic signed [DW-1:0] exp_q [$];
  logic signed [DW-1:0] last_out;
  longint               m_xp, m_yp;
  longint               m_taps [NTAPS];
  int                   n_checks;
  int                   n_fail;

  task automatic check(input string name, input logic signed [DW-1:0] act,
                       input logic signed [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_xp = 0;
    m_yp = 0;
    for (int i = 0; i < NTAPS; i++) m_taps[i] = 0;
  endtask

  task automatic model_step(input longint x, output longint o);
    longint d, p, y, s;
    d = x - m_xp;
    p = (longint'(ALPHA) * m_yp) >>> 15;
    y = d + p;
    if (y > 64'sd2147483647) y = 64'sd2147483647;
    if (y < -64'sd2147483648) y = -64'sd2147483648;
    m_xp = x;
    m_yp = y;
    for (int i = NTAPS - 1; i > 0; i--) m_taps[i] = m_taps[i-1];
    m_taps[0] = y;
    s = 0;
    for (int i = 0; i < NTAPS; i++) s += m_taps[i];
    o = s >>> 3;
  endtask

  // One strobe period: the result is due 13 posedges after the strobe rises at a negedge
  // (2 sync flops, then the tick cycle, then NTAPS+2 processing cycles).
  task automatic apply(input logic signed [DW-1:0] v, input logic en, input logic use_model,
                       input logic signed [DW-1:0] tbl_exp, input string name);
    longint               mo;
    logic signed [DW-1:0] e;
    logic signed [DW-1:0] hold;
    hold = last_out;
    @(negedge clk);
    in_signal    = v;
    enable       = en;
    sampling_clk = 1'b1;
    if (en) begin
      model_step(longint'(v), mo);
      exp_q.push_back(use_model ? 32'(mo) : tbl_exp);
    end
    repeat (12) @(posedge clk);
    @(negedge clk);
    check({name, "_not_early"}, out_signal, hold);
    @(negedge clk);
    if (en) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s: got no expected entry, required one queued", name);
      end else begin
        e = exp_q.pop_front();
        check(name, out_signal, e);
        last_out = e;
      end
    end else begin
      check({name, "_ignored"}, out_signal, hold);
    end
    repeat (20) @(negedge clk);
    sampling_clk = 1'b0;
    repeat (32) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst          = 1'b1;
    sampling_clk = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    last_out = '0;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    rst          = 1'b1;
    sampling_clk = 1'b0;
    enable       = 1'b0;
    in_signal    = '0;
    last_out     = '0;
    model_reset();

    // Step, enable gating, restart and negative floor division, all hand-derived.
    vecs[0] = '{din: 32'sd1000,   en: 1'b1, exp_out: 32'sd125};
    vecs[1] = '{din: 32'sd1000,   en: 1'b1, exp_out: 32'sd248};
    vecs[2] = '{din: 32'sd5000,   en: 1'b0, exp_out: 32'sd248};
    vecs[3] = '{din: 32'sd5000,   en: 1'b0, exp_out: 32'sd248};
    vecs[4] = '{din: 32'sd0,      en: 1'b1, exp_out: 32'sd246};
    vecs[5] = '{din: 32'sd1000,   en: 1'b1, exp_out: 32'sd368};
    vecs[6] = '{din: -32'sd1000,  en: 1'b1, exp_out: 32'sd239};
    vecs[7] = '{din: -32'sd30000, en: 1'b1, exp_out: -32'sd3514};

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_signal    = $urandom;
      enable       = 1'($urandom);
      sampling_clk = 1'($urandom);
      check("reset_out", out_signal, '0);
    end
    @(negedge clk);
    sampling_clk = 1'b0;
    enable       = 1'b0;
    in_signal    = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("idle_after_reset", out_signal, '0);

    for (int i = 0; i < 8; i++)
      apply(vecs[i].din, vecs[i].en, 1'b0, vecs[i].exp_out, $sformatf("vec%0d", i));

    // Reset four cycles into MAC: output clears at once, partial result never appears.
    @(negedge clk);
    in_signal    = 32'sd2000;
    enable       = 1'b1;
    sampling_clk = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("pre_rst_hold", out_signal, last_out);
    rst = 1'b1;
    #1;
    check("rst_mid_mac", out_signal, '0);
    sampling_clk = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    last_out = '0;
    repeat (30) @(negedge clk);
    check("no_partial_output", out_signal, '0);
    apply(32'sd1000, 1'b1, 1'b0, 32'sd125, "post_reset_step");

    // From a clean state: x_prev = -2^31 (y = -2^31), then +2^31-1 clamps y to +2^31-1,
    // so the taps sum to -1 and the mean floors to -1 (a wrapped y would give -534183937).
    do_reset();
    apply(32'sh80000000, 1'b1, 1'b0, -32'sd268435456, "sat_neg_fill");
    apply(32'sh7FFFFFFF, 1'b1, 1'b0, -32'sd1, "sat_pos_clamp");

    for (int i = 0; i < 40; i++) begin
      logic signed [DW-1:0] v;
      logic                 en;
      v  = (i % 7 == 3) ? $urandom : DW'($signed($urandom_range(0, 400000)) - 200000);
      en = ($urandom_range(0, 5) != 0);
      apply(v, en, 1'b1, '0, $sformatf("rand%0d", i));
    end

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drained: got %0d entries left, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
